// File: rtl/decode_rf_scoreboard.sv
// Decode-stage register file with WB bypass, MEM late forward and a per-register
// pending-write scoreboard that produces the decode stall.
module decode_rf_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_sel,
  input  logic [NRD-1:0]        rd_use,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [AW-1:0]         issue_dst,
  output logic                  stall,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  fwd_valid,
  input  logic [AW-1:0]         fwd_sel,
  input  logic [DATA_W-1:0]     fwd_data,
  output logic                  pend_any,
  output logic                  err
);

  localparam int            CW      = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CW-1:0]     cnt_q  [NREG];
  logic [CW-1:0]     cnt_d  [NREG];
  logic              err_q, err_d;
  logic [NREG-1:0]   inc_vec, dec_vec;
  logic              src_ok;
  logic              dst_full;
  logic              accept;

  // Read ports: late forward beats WB bypass, which beats stored data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (fwd_valid && fwd_sel == rd_sel[i*AW +: AW])
        rd_data[i*DATA_W +: DATA_W] = fwd_data;
      else if (wr_en && wr_sel == rd_sel[i*AW +: AW])
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      else
        rd_data[i*DATA_W +: DATA_W] = regs_q[rd_sel[i*AW +: AW]];
    end
  end

  // Source readiness: a single pending write is only usable if its value arrives this cycle.
  always_comb begin
    src_ok = 1'b1;
    for (int i = 0; i < NRD; i++) begin
      if (rd_use[i]) begin
        if (cnt_q[rd_sel[i*AW +: AW]] == CNT_ONE) begin
          if (!((fwd_valid && fwd_sel == rd_sel[i*AW +: AW]) ||
                (wr_en && wr_sel == rd_sel[i*AW +: AW])))
            src_ok = 1'b0;
        end else if (cnt_q[rd_sel[i*AW +: AW]] != '0) begin
          src_ok = 1'b0;
        end
      end
    end
  end

  // A full destination counter blocks issue unless a retire frees a slot the same cycle.
  assign dst_full = issue_wr && (cnt_q[issue_dst] == CNT_MAX) &&
                    !(wr_en && wr_sel == issue_dst);
  assign stall    = issue_valid && (!src_ok || dst_full);
  assign accept   = issue_valid && !stall;

  // One-hot increment (accepted writer) and decrement (retire) per register.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept && issue_wr) inc_vec[issue_dst] = 1'b1;
    if (wr_en)              dec_vec[wr_sel]    = 1'b1;
  end

  // Scoreboard next state: coincident inc/dec cancel; underflow/overflow flag err and clamp.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (dec_vec[r] && cnt_q[r] == '0) err_d = 1'b1;
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r] && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // State registers: storage, counters and sticky error, synchronous reset first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      // NOTE: the storage array is reset too, because reads of never-written registers must return 0.
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      if (wr_en) regs_q[wr_sel] <= wr_data;
      err_q <= err_d;
    end
  end

  // Any register with in-flight writes, from registered counts only.
  always_comb begin
    pend_any = 1'b0;
    for (int r = 0; r < NREG; r++) if (cnt_q[r] != '0) pend_any = 1'b1;
  end

  assign err = err_q;

endmodule

// File: tb/tb_decode_rf_scoreboard.sv
// Testbench for decode_rf_scoreboard: directed scenarios plus randomized traffic
// checked against a count-based reference model of the register file and scoreboard.
module tb_decode_rf_scoreboard;

  localparam int DATA_W   = 16;
  localparam int NREG     = 8;
  localparam int AW       = 3;
  localparam int NRD      = 2;
  localparam int MAX_PEND = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NRD*AW-1:0]     rd_sel;
  logic [NRD-1:0]        rd_use;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  issue_valid, issue_wr;
  logic [AW-1:0]         issue_dst;
  logic                  stall;
  logic                  wr_en;
  logic [AW-1:0]         wr_sel;
  logic [DATA_W-1:0]     wr_data;
  logic                  fwd_valid;
  logic [AW-1:0]         fwd_sel;
  logic [DATA_W-1:0]     fwd_data;
  logic                  pend_any, err;

  int vectors;
  int miscompares;

  // Reference model state
  logic [DATA_W-1:0] m_reg [NREG];
  int                m_cnt [NREG];
  bit                m_err;

  decode_rf_scoreboard #(
    .DATA_W(DATA_W), .NREG(NREG), .AW(AW), .NRD(NRD), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_sel(rd_sel), .rd_use(rd_use), .rd_data(rd_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .stall(stall),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .pend_any(pend_any), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] exp_rd(input int p);
    logic [AW-1:0] s;
    s = rd_sel[p*AW +: AW];
    if (fwd_valid && fwd_sel == s) return fwd_data;
    if (wr_en && wr_sel == s)      return wr_data;
    return m_reg[s];
  endfunction

  function automatic bit value_arrives(input logic [AW-1:0] s);
    return (fwd_valid && fwd_sel == s) || (wr_en && wr_sel == s);
  endfunction

  function automatic bit exp_stall();
    logic [AW-1:0] s;
    if (!issue_valid) return 1'b0;
    for (int p = 0; p < NRD; p++) begin
      s = rd_sel[p*AW +: AW];
      if (rd_use[p] && !(m_cnt[s] == 0 || (m_cnt[s] == 1 && value_arrives(s)))) return 1'b1;
    end
    if (issue_wr && m_cnt[issue_dst] == MAX_PEND && !(wr_en && wr_sel == issue_dst)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_pend();
    int total;
    total = 0;
    for (int r = 0; r < NREG; r++) total += m_cnt[r];
    return total > 0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    bit acc;
    int issues, retires, n;
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
      m_err = 1'b0;
      return;
    end
    acc = issue_valid && !exp_stall();
    for (int r = 0; r < NREG; r++) begin
      issues  = (acc && issue_wr && issue_dst == r) ? 1 : 0;
      retires = (wr_en && wr_sel == r) ? 1 : 0;
      if (retires == 1 && m_cnt[r] == 0) m_err = 1'b1;
      n = m_cnt[r] + issues - retires;
      if (n > MAX_PEND) begin m_err = 1'b1; n = MAX_PEND; end
      if (n < 0) n = 0;
      m_cnt[r] = n;
    end
    if (wr_en) m_reg[wr_sel] = wr_data;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rd_sel = '0; rd_use = '0;
    issue_valid = 1'b0; issue_wr = 1'b0; issue_dst = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    fwd_valid = 1'b0; fwd_sel = '0; fwd_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h1234;   // must lose to reset
    tick();
    idle();
    rst_n = 1'b1;
    issue_valid = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      rd_sel = {AW'(r), AW'(NREG - 1 - r)};
      #1;
      for (int p = 0; p < NRD; p++) begin
        vectors++;
        if (rd_data[p*DATA_W +: DATA_W] !== 16'h0000) begin
          miscompares++;
          $display("FAIL reset_rd r%0d p%0d: got %h want 0000", r, p, rd_data[p*DATA_W +: DATA_W]);
        end
      end
    end
    vectors++;
    if (pend_any !== 1'b0) begin miscompares++; $display("FAIL reset_pend: got %b want 0", pend_any); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF;
    rd_sel[0 +: AW] = 3'd3;
    #1;
    vectors++;
    if (rd_data[0 +: DATA_W] !== 16'hBEEF) begin
      miscompares++; $display("FAIL bypass_same_cycle: got %h want beef", rd_data[0 +: DATA_W]);
    end
    tick();
    idle();
    rd_sel[0 +: AW] = 3'd3;
    #1;
    vectors++;
    if (rd_data[0 +: DATA_W] !== 16'hBEEF) begin
      miscompares++; $display("FAIL bypass_stored: got %h want beef", rd_data[0 +: DATA_W]);
    end
    // forward outranks the WB bypass on the same register
    fwd_valid = 1'b1; fwd_sel = 3'd3; fwd_data = 16'h1111;
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h2222;
    rd_sel[AW +: AW] = 3'd3;
    #1;
    vectors++;
    if (rd_data[DATA_W +: DATA_W] !== 16'h1111) begin
      miscompares++; $display("FAIL fwd_priority: got %h want 1111", rd_data[DATA_W +: DATA_W]);
    end
    idle();
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_dst = 3'd2;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL raw_issue: got stall %b want 0", stall); end
    tick();
    idle();
    issue_valid = 1'b1; rd_use = 2'b01; rd_sel[0 +: AW] = 3'd2;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL raw_hold%0d: got stall %b want 1", k, stall); end
      tick();
    end
    vectors++;
    if (pend_any !== 1'b1) begin miscompares++; $display("FAIL raw_pend: got %b want 1", pend_any); end
    fwd_valid = 1'b1; fwd_sel = 3'd2; fwd_data = 16'h0042;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL raw_release: got stall %b want 0", stall); end
    vectors++;
    if (rd_data[0 +: DATA_W] !== 16'h0042) begin
      miscompares++; $display("FAIL raw_fwd_data: got %h want 0042", rd_data[0 +: DATA_W]);
    end
    tick();
    idle();
    wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h0042;
    tick();
    idle();
    #1;
    vectors++;
    if (pend_any !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL raw_retire: got pend %b err %b want 0 0", pend_any, err);
    end
  endtask

  task automatic test_double_pending();
    do_reset();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_dst = 3'd5;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL dbl_issue%0d: got stall %b want 0", k, stall); end
      tick();
    end
    idle();
    issue_valid = 1'b1; rd_use = 2'b10; rd_sel[AW +: AW] = 3'd5;
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h5A5A;
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL dbl_stale: got stall %b want 1", stall); end
    tick();
    wr_en = 1'b0;
    fwd_valid = 1'b1; fwd_sel = 3'd5; fwd_data = 16'h0055;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL dbl_accept: got stall %b want 0", stall); end
    vectors++;
    if (rd_data[DATA_W +: DATA_W] !== 16'h0055) begin
      miscompares++; $display("FAIL dbl_fwd_data: got %h want 0055", rd_data[DATA_W +: DATA_W]);
    end
    tick();
    idle();
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h0055;
    tick();
    idle();
    #1;
    vectors++;
    if (pend_any !== 1'b0) begin miscompares++; $display("FAIL dbl_drain: got pend %b want 0", pend_any); end
  endtask

  task automatic test_saturation();
    do_reset();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_dst = 3'd1;
    for (int k = 0; k < MAX_PEND; k++) begin
      #1;
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL sat_issue%0d: got stall %b want 0", k, stall); end
      tick();
    end
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL sat_full: got stall %b want 1", stall); end
    tick();
    wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'h0101;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL sat_retire_issue: got stall %b want 0", stall); end
    tick();
    wr_en = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL sat_still_full: got stall %b want 1", stall); end
    idle();
    for (int k = 0; k < MAX_PEND; k++) begin
      wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'(k);
      tick();
    end
    idle();
    #1;
    vectors++;
    if (pend_any !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL sat_drain: got pend %b err %b want 0 0", pend_any, err);
    end
  endtask

  task automatic test_error();
    do_reset();
    wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h6666;
    tick();
    idle();
    rd_sel[0 +: AW] = 3'd6;
    #1;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", err); end
    vectors++;
    if (rd_data[0 +: DATA_W] !== 16'h6666) begin
      miscompares++; $display("FAIL err_data_written: got %h want 6666", rd_data[0 +: DATA_W]);
    end
    tick();
    tick();
    #1;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b want 0", err); end
  endtask

  task automatic test_random();
    int start, pick;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 79) != 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_wr    = 1'($urandom_range(0, 1));
      issue_dst   = AW'($urandom_range(0, 3));
      rd_sel      = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      rd_use      = NRD'($urandom_range(0, 3));
      // retire only registers the model knows are pending
      wr_en = 1'b0; wr_sel = '0; wr_data = 16'($urandom);
      start = $urandom_range(0, NREG - 1);
      pick  = -1;
      for (int k = 0; k < NREG; k++)
        if (pick < 0 && m_cnt[(start + k) % NREG] > 0) pick = (start + k) % NREG;
      if (pick >= 0 && $urandom_range(0, 2) != 0) begin
        wr_en = 1'b1; wr_sel = AW'(pick);
      end
      fwd_valid = ($urandom_range(0, 2) == 0);
      fwd_sel   = AW'($urandom_range(0, 3));
      fwd_data  = 16'($urandom);
      #1;
      for (int p = 0; p < NRD; p++) begin
        vectors++;
        if (rd_data[p*DATA_W +: DATA_W] !== exp_rd(p)) begin
          miscompares++;
          $display("FAIL rand_rd n%0d p%0d: got %h want %h", n, p, rd_data[p*DATA_W +: DATA_W], exp_rd(p));
        end
      end
      vectors++;
      if (stall !== exp_stall()) begin
        miscompares++; $display("FAIL rand_stall n%0d: got %b want %b", n, stall, exp_stall());
      end
      vectors++;
      if (pend_any !== exp_pend()) begin
        miscompares++; $display("FAIL rand_pend n%0d: got %b want %b", n, pend_any, exp_pend());
      end
      vectors++;
      if (err !== m_err) begin
        miscompares++; $display("FAIL rand_err n%0d: got %b want %b", n, err, m_err);
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
    m_err = 1'b0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_raw_stall();
    test_double_pending();
    test_saturation();
    test_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
